butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter N, default 16: signed two's-complement width of each data/twiddle component.
REQ-002 Parameter FRAC, default 14: twiddle fractional bits; 1.0 = 2^FRAC.
REQ-003 Parameter MULT_LAT, default 4, range 1..8: complex-multiply pipeline stages.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 in_valid  in  1  input operand set valid.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 Ar, Ai, Br, Bi  in  N each  operands A, B (signed).
REQ-009 Tr, Ti  in  N each  twiddle (signed, Q(N-FRAC).FRAC).
REQ-010 scale  in  1  per-input: 1 = halve results (rounded).
REQ-011 inverse  in  1  per-input: 1 = use conjugate twiddle.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 Cr, Ci, Dr, Di  out  N each  C = A + B*T', D = A - B*T' (T' = T or conj T).
REQ-015 ovf  out  1  sticky saturation flag.
REQ-016 ovf_clr  in  1  clears ovf.

Function
REQ-017 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-018 in_ready SHALL equal !(out_valid && !out_ready); the whole pipeline advances when in_ready = 1, holds all state otherwise.
REQ-019 Latency SHALL be exactly MULT_LAT+1 advancing cycles from input acceptance to out_valid; throughput one per cycle.
REQ-020 A, scale, inverse SHALL be delayed alongside the product so each result uses its own operands and modes.
REQ-021 Empty stages (bubbles) propagate with valid = 0; outputs hold their last values while out_valid = 0.
REQ-022 Product P = B*T' computed at full 2N+1 bits, rounded by adding 2^(FRAC-1) then arithmetic right shift FRAC, kept at N+2 bits, no intermediate saturation.
REQ-023 Sums A+P, A-P formed at N+2 bits; if scale = 1, add 1 then arithmetic shift right 1 (round half up).
REQ-024 Each component SHALL saturate to [-2^(N-1), 2^(N-1)-1].
REQ-025 Any saturation on a transferred-out-of-pipe result SHALL set ovf on that cycle; ovf holds until ovf_clr.
REQ-026 ovf_clr and new saturation in the same cycle: ovf = 1 (set wins).
REQ-027 Result order SHALL equal input order; no result dropped or duplicated under any out_ready pattern.

Reset
REQ-028 Reset asserted: all stage valids, out_valid, ovf and Cr/Ci/Dr/Di SHALL go to 0 immediately, without a clock edge.
REQ-029 In-flight data at reset SHALL be discarded; no result emerges from pre-reset inputs.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid = 0).

Structure
REQ-031 Shared package holds round/saturate helpers and the default N, FRAC, MULT_LAT constants.
REQ-032 Complex multiply SHALL be one sub-module, cmult_pipe (parametrised N, FRAC, MULT_LAT, with enable), instanced once; add/sub/scale/saturate stage in butterfly_pipe.

Verification (N=16, FRAC=14, MULT_LAT=4)
REQ-033 T=(16384,0), A=(100,50), B=(20,-10), scale=0, inverse=0 -> after 5 cycles C=(120,40), D=(80,60), ovf=0.
REQ-034 T=(0,-16384), same A, B: inverse=0 -> C=(90,30), D=(110,70); inverse=1 -> C=(110,70), D=(90,30).
REQ-035 T=(16384,0), A=(32000,0), B=(32000,0): scale=0 -> Cr=32767, Dr=0, ovf=1; scale=1 -> Cr=32000, Dr=0, ovf=0; A=(3,0), B=0, scale=1 -> Cr=2.
REQ-036 8 back-to-back inputs, out_ready=0 for 3 cycles while 2nd result valid -> in_ready=0 during stall, all 8 results in order, none lost.
REQ-037 Reset pulse with 3 inputs in flight -> out_valid=0 immediately, no stale results afterwards; ovf_clr with simultaneous saturation -> ovf stays 1.

Source files
------------

// File: rtl/butterfly_pipe_pkg.sv
// Shared constants and fixed-point helpers for the radix-2 butterfly pipeline.
// Helpers work on 64-bit signed values; callers size-cast in and out.
package butterfly_pipe_pkg;

  localparam int BF_N        = 16;
  localparam int BF_FRAC     = 14;
  localparam int BF_MULT_LAT = 4;

  // Round half up, then arithmetic shift right by sh.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] x, input int sh);
    if (sh <= 0) return x;
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int n);
    return sat_clip(x, n) != x;
  endfunction

endpackage

// File: rtl/butterfly_pipe_cmult.sv
// Pipelined complex multiply P = B * T' (T' = conj T when inverse), rounded to N+2 bits.
// Full-precision sums travel down the pipe; rounding is applied on the way out.
module cmult_pipe
  import butterfly_pipe_pkg::*;
#(
  parameter int N        = BF_N,
  parameter int FRAC     = BF_FRAC,
  parameter int MULT_LAT = BF_MULT_LAT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic signed [N-1:0] i_br,
  input  logic signed [N-1:0] i_bi,
  input  logic signed [N-1:0] i_tr,
  input  logic signed [N-1:0] i_ti,
  input  logic                i_inverse,
  output logic                o_valid,
  output logic signed [N+1:0] o_pr,
  output logic signed [N+1:0] o_pi
);

  logic signed [2*N-1:0] w_rr, w_ii, w_ir, w_ri;
  logic signed [2*N:0]   w_sr, w_si;
  logic signed [2*N:0]   r_sr [MULT_LAT];
  logic signed [2*N:0]   r_si [MULT_LAT];
  logic [MULT_LAT-1:0]   r_valid;

  assign w_rr = i_br * i_tr;
  assign w_ii = i_bi * i_ti;
  assign w_ir = i_bi * i_tr;
  assign w_ri = i_br * i_ti;

  // Conjugating T only flips the sign of the Ti cross terms.
  assign w_sr = i_inverse ? ((2*N+1)'(w_rr) + (2*N+1)'(w_ii)) : ((2*N+1)'(w_rr) - (2*N+1)'(w_ii));
  assign w_si = i_inverse ? ((2*N+1)'(w_ir) - (2*N+1)'(w_ri)) : ((2*N+1)'(w_ir) + (2*N+1)'(w_ri));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        r_sr[k] <= '0;
        r_si[k] <= '0;
      end
    end else if (i_en) begin
      r_valid[0] <= i_valid;
      r_sr[0]    <= w_sr;
      r_si[0]    <= w_si;
      for (int k = 1; k < MULT_LAT; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_sr[k]    <= r_sr[k-1];
        r_si[k]    <= r_si[k-1];
      end
    end
  end

  assign o_valid = r_valid[MULT_LAT-1];
  assign o_pr    = (N+2)'(round_shr(64'(r_sr[MULT_LAT-1]), FRAC));
  assign o_pi    = (N+2)'(round_shr(64'(r_si[MULT_LAT-1]), FRAC));

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 butterfly: C = A + B*T', D = A - B*T', optional halving, saturation and sticky overflow.
// One global enable stalls every stage whenever a valid result is held at the output.
module butterfly_pipe
  import butterfly_pipe_pkg::*;
#(
  parameter int N        = BF_N,
  parameter int FRAC     = BF_FRAC,
  parameter int MULT_LAT = BF_MULT_LAT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic signed [N-1:0] i_ar,
  input  logic signed [N-1:0] i_ai,
  input  logic signed [N-1:0] i_br,
  input  logic signed [N-1:0] i_bi,
  input  logic signed [N-1:0] i_tr,
  input  logic signed [N-1:0] i_ti,
  input  logic                i_scale,
  input  logic                i_inverse,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic signed [N-1:0] o_cr,
  output logic signed [N-1:0] o_ci,
  output logic signed [N-1:0] o_dr,
  output logic signed [N-1:0] o_di,
  output logic                o_ovf,
  input  logic                i_ovf_clr
);

  logic                w_en;
  logic                w_valid_m;
  logic signed [N+1:0] w_pr, w_pi;
  logic signed [N+1:0] w_a_r, w_a_i;
  logic signed [N+1:0] w_sum    [4];
  logic signed [N+1:0] w_rnd    [4];
  logic signed [N+1:0] w_scaled [4];
  logic signed [N-1:0] w_res    [4];
  logic                w_any_sat;

  logic signed [N-1:0] r_ar_d    [MULT_LAT];
  logic signed [N-1:0] r_ai_d    [MULT_LAT];
  logic [MULT_LAT-1:0] r_scale_d;
  logic                r_out_valid;
  logic signed [N-1:0] r_cr, r_ci, r_dr, r_di;
  logic                r_ovf;

  assign w_en       = !(r_out_valid && !i_out_ready);
  assign o_in_ready = w_en;

  cmult_pipe #(
    .N       (N),
    .FRAC    (FRAC),
    .MULT_LAT(MULT_LAT)
  ) u_cmult (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (w_en),
    .i_valid  (i_in_valid),
    .i_br     (i_br),
    .i_bi     (i_bi),
    .i_tr     (i_tr),
    .i_ti     (i_ti),
    .i_inverse(i_inverse),
    .o_valid  (w_valid_m),
    .o_pr     (w_pr),
    .o_pi     (w_pi)
  );

  // A and scale ride alongside the multiplier so each result uses its own operands.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scale_d <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        r_ar_d[k] <= '0;
        r_ai_d[k] <= '0;
      end
    end else if (w_en) begin
      r_ar_d[0]    <= i_ar;
      r_ai_d[0]    <= i_ai;
      r_scale_d[0] <= i_scale;
      for (int k = 1; k < MULT_LAT; k++) begin
        r_ar_d[k]    <= r_ar_d[k-1];
        r_ai_d[k]    <= r_ai_d[k-1];
        r_scale_d[k] <= r_scale_d[k-1];
      end
    end
  end

  assign w_a_r = (N+2)'(r_ar_d[MULT_LAT-1]);
  assign w_a_i = (N+2)'(r_ai_d[MULT_LAT-1]);

  always_comb begin
    w_sum[0]  = w_a_r + w_pr;
    w_sum[1]  = w_a_i + w_pi;
    w_sum[2]  = w_a_r - w_pr;
    w_sum[3]  = w_a_i - w_pi;
    w_any_sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_rnd[k]    = w_sum[k] + (N+2)'(1);
      w_scaled[k] = r_scale_d[MULT_LAT-1] ? (w_rnd[k] >>> 1) : w_sum[k];
      w_res[k]    = N'(sat_clip(64'(w_scaled[k]), N));
      w_any_sat   = w_any_sat | sat_hit(64'(w_scaled[k]), N);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_cr        <= '0;
      r_ci        <= '0;
      r_dr        <= '0;
      r_di        <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_en) begin
        r_out_valid <= w_valid_m;
        if (w_valid_m) begin
          r_cr <= w_res[0];
          r_ci <= w_res[1];
          r_dr <= w_res[2];
          r_di <= w_res[3];
        end
      end
      // A new saturation outranks a simultaneous clear.
      if (w_en && w_valid_m && w_any_sat) r_ovf <= 1'b1;
      else if (i_ovf_clr)                 r_ovf <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_cr        = r_cr;
  assign o_ci        = r_ci;
  assign o_dr        = r_dr;
  assign o_di        = r_di;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (N=16, FRAC=14, MULT_LAT=4).
module tb_butterfly_pipe;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic scale, inverse, ovf, ovf_clr;
  logic signed [N-1:0] ar, ai, br, bi, tr, ti, cr, ci, dr, di;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  butterfly_pipe #(.N(16), .FRAC(14), .MULT_LAT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_ar(ar), .i_ai(ai), .i_br(br), .i_bi(bi), .i_tr(tr), .i_ti(ti),
    .i_scale(scale), .i_inverse(inverse), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_cr(cr), .o_ci(ci), .o_dr(dr), .o_di(di), .o_ovf(ovf), .i_ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_op(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int t_r, input int t_i, input logic sc, input logic inv);
    ar = N'(a_r); ai = N'(a_i); br = N'(b_r); bi = N'(b_i);
    tr = N'(t_r); ti = N'(t_i); scale = sc; inverse = inv;
  endtask

  // Called at the negedge after acceptance; start = edges already elapsed since acceptance.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One isolated operation, returns when its result is at the output.
  task automatic one_op(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int t_r, input int t_i, input logic sc, input logic inv,
                        output int lat);
    @(negedge clk);
    set_op(a_r, a_i, b_r, b_i, t_r, t_i, sc, inv);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(1, lat);
  endtask

  initial begin
    int lat;
    int k_in, k_out, stall, cyc, stale;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_cr", cr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Unity twiddle
    one_op(100, 50, 20, -10, 16384, 0, 1'b0, 1'b0, lat);
    chk("unity_latency", lat, 5);
    chk("unity_cr", cr, 120);
    chk("unity_ci", ci, 40);
    chk("unity_dr", dr, 80);
    chk("unity_di", di, 60);
    chk("unity_ovf", ovf, 0);
    @(negedge clk);
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_hold_cr", cr, 120);

    // -j twiddle, forward then inverse back to back
    @(negedge clk);
    set_op(100, 50, 20, -10, 0, -16384, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    inverse = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(2, lat);
    chk("mj_latency", lat, 5);
    chk("mj_fwd_cr", cr, 90);
    chk("mj_fwd_ci", ci, 30);
    chk("mj_fwd_dr", dr, 110);
    chk("mj_fwd_di", di, 70);
    @(negedge clk);
    chk("mj_inv_valid", out_valid, 1);
    chk("mj_inv_cr", cr, 110);
    chk("mj_inv_ci", ci, 70);
    chk("mj_inv_dr", dr, 90);
    chk("mj_inv_di", di, 30);

    // Saturation, scaling, rounding
    one_op(32000, 0, 32000, 0, 16384, 0, 1'b0, 1'b0, lat);
    chk("sat_cr", cr, 32767);
    chk("sat_dr", dr, 0);
    chk("sat_ovf", ovf, 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    one_op(32000, 0, 32000, 0, 16384, 0, 1'b1, 1'b0, lat);
    chk("scale_cr", cr, 32000);
    chk("scale_dr", dr, 0);
    chk("scale_ovf", ovf, 0);
    one_op(3, 0, 0, 0, 16384, 0, 1'b1, 1'b0, lat);
    chk("round_pos_cr", cr, 2);
    chk("round_pos_dr", dr, 2);
    one_op(-3, 0, 0, 0, 16384, 0, 1'b1, 1'b0, lat);
    chk("round_neg_cr", cr, -1);
    one_op(-32000, 0, 32000, 0, 16384, 0, 1'b0, 1'b0, lat);
    chk("negsat_cr", cr, 0);
    chk("negsat_dr", dr, -32768);
    chk("negsat_ovf", ovf, 1);
    @(negedge clk);

    // Stream of 8 with a 3-cycle stall on the 2nd result
    k_in = 0; k_out = 0; stall = 0; cyc = 0;
    while (k_out < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      out_ready = !(out_valid && k_out == 1 && stall < 3);
      #1;
      if (!out_ready) begin
        stall++;
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        chk("stream_cr", cr, 11 * k_out + 10);
        chk("stream_ci", ci, -k_out);
        chk("stream_dr", dr, 9 * k_out + 10);
        chk("stream_di", di, -k_out - 2);
        k_out++;
      end
      if (k_in < 8) begin
        set_op(10 * (k_in + 1), -(k_in + 1), k_in, 1, 16384, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        if (in_ready) k_in++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", k_out, 8);
    chk("stream_stalls", stall, 3);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with three results in flight
    @(negedge clk);
    set_op(32000, 0, 32000, 0, 16384, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      set_op(5, 5, 1, 1, 16384, 0, 1'b0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(4, lat);
    chk("pre_rst_latency", lat, 5);
    chk("pre_rst_cr", cr, 32767);
    chk("pre_rst_ovf", ovf, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_cr", cr, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("stale_results", stale, 0);

    // Clear coinciding with a new saturation
    @(negedge clk);
    set_op(-32000, 0, -32000, 0, 16384, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("clr_race_valid", out_valid, 1);
    chk("clr_race_cr", cr, -32768);
    chk("clr_race_ovf", ovf, 1);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
